// File: rtl/tytra_kernel_ctrl_multi.sv
// Multi-channel kernel control sequencer: ap_start edge -> per-channel start pulses, sticky done aggregation, busy counter.
// Optional ap_ctrl_chain handshake when TYTRA_KERNEL_CTRL_CHAIN_EN is defined (default is ap_ctrl_hs).
module tytra_kernel_ctrl_multi #(
  parameter int NUM_CH                     = 4,
  parameter int C_XFER_SIZE_WIDTH          = 32,
  parameter int LP_DEFAULT_LENGTH_IN_BYTES = 16384,
  parameter int C_CYCLE_CNT_WIDTH          = 48
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  input  logic                         ap_continue,
  output logic                         ap_idle,
  output logic                         ap_ready,
  output logic                         ap_done,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [C_XFER_SIZE_WIDTH-1:0] xfer_size_in_bytes,
  output logic [NUM_CH-1:0]            ch_start,
  output logic [C_XFER_SIZE_WIDTH-1:0] ch_xfer_size,
  input  logic [NUM_CH-1:0]            ch_done,
  output logic [NUM_CH-1:0]            ch_done_status,
  output logic [C_CYCLE_CNT_WIDTH-1:0] busy_cycles
);

  // state  | meaning
  // IDLE   | waiting for a rising edge of ap_start
  // LAUNCH | one cycle: start pulses to enabled channels, ap_ready
  // RUN    | collecting done flags of enabled channels
  // DONE   | ap_done asserted; one cycle (hs) or until ap_continue (chain)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [C_XFER_SIZE_WIDTH-1:0] DEFAULT_SIZE =
    C_XFER_SIZE_WIDTH'(LP_DEFAULT_LENGTH_IN_BYTES);

  state_t                       state;
  state_t                       state_nxt;
  logic                         ap_start_q;
  logic                         start_pulse;
  logic [NUM_CH-1:0]            mask_r;
  logic [NUM_CH-1:0]            done_merge;
  logic                         run_complete;
  logic                         enter_done;
  logic [C_CYCLE_CNT_WIDTH-1:0] cycle_cnt;
  logic [C_CYCLE_CNT_WIDTH-1:0] cycle_cnt_inc;

  assign start_pulse   = ap_start & ~ap_start_q;
  assign done_merge    = ch_done_status | (ch_done & mask_r);
  assign run_complete  = (done_merge == mask_r);
  assign enter_done    = (state != DONE) && (state_nxt == DONE);
  assign cycle_cnt_inc = (&cycle_cnt) ? cycle_cnt : cycle_cnt + C_CYCLE_CNT_WIDTH'(1);

`ifndef TYTRA_KERNEL_CTRL_CHAIN_EN
  logic unused_ap_continue;
  assign unused_ap_continue = ap_continue;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      ap_start_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      ap_start_q <= ap_start;
    end
  end

  always_comb begin
    state_nxt = state;
    ap_idle   = 1'b0;
    ap_ready  = 1'b0;
    ap_done   = 1'b0;
    ch_start  = '0;
    case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (start_pulse) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        ap_ready  = 1'b1;
        ch_start  = mask_r;
        state_nxt = (mask_r == '0) ? DONE : RUN;
      end
      RUN: begin
        if (run_complete) state_nxt = DONE;
      end
      DONE: begin
        ap_done = 1'b1;
`ifdef TYTRA_KERNEL_CTRL_CHAIN_EN
        if (ap_continue) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run configuration and done tracking; busy_cycles captures the count including the cycle entering DONE.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mask_r         <= '0;
      ch_xfer_size   <= DEFAULT_SIZE;
      ch_done_status <= '0;
      cycle_cnt      <= '0;
      busy_cycles    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_pulse) begin
            mask_r         <= ch_enable;
            ch_xfer_size   <= (xfer_size_in_bytes == '0) ? DEFAULT_SIZE : xfer_size_in_bytes;
            ch_done_status <= '0;
            cycle_cnt      <= '0;
          end
        end
        LAUNCH: begin
          cycle_cnt <= cycle_cnt_inc;
        end
        RUN: begin
          ch_done_status <= done_merge;
          cycle_cnt      <= cycle_cnt_inc;
        end
        default: ;
      endcase
      if (enter_done) busy_cycles <= cycle_cnt_inc;
    end
  end

endmodule

// File: tb/tb_tytra_kernel_ctrl_multi.sv
// Self-checking bench for tytra_kernel_ctrl_multi: timeline model compared every cycle plus literal checks.
module tb_tytra_kernel_ctrl_multi;

  localparam int NUM_CH = 4;
  localparam int XW     = 32;
  localparam int CW     = 48;
  localparam int DEF_SZ = 16384;
  localparam int NEVER  = 32'h3fffffff;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n = 1'b0;
  logic            ap_start = 1'b0;
  logic            ap_continue = 1'b0;
  logic            ap_idle, ap_ready, ap_done;
  logic [NUM_CH-1:0] ch_enable = '0;
  logic [XW-1:0]   xfer_size_in_bytes = '0;
  logic [NUM_CH-1:0] ch_start;
  logic [XW-1:0]   ch_xfer_size;
  logic [NUM_CH-1:0] ch_done = '0;
  logic [NUM_CH-1:0] ch_done_status;
  logic [CW-1:0]   busy_cycles;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  tytra_kernel_ctrl_multi #(
    .NUM_CH(NUM_CH), .C_XFER_SIZE_WIDTH(XW),
    .LP_DEFAULT_LENGTH_IN_BYTES(DEF_SZ), .C_CYCLE_CNT_WIDTH(CW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
    .ch_enable(ch_enable), .xfer_size_in_bytes(xfer_size_in_bytes),
    .ch_start(ch_start), .ch_xfer_size(ch_xfer_size),
    .ch_done(ch_done), .ch_done_status(ch_done_status), .busy_cycles(busy_cycles)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a run is described by its start edge, latched mask/size and the edge ap_done begins.
  int              m_cyc = 0;
  int              m_t0 = 0;
  int              m_tdone = NEVER;
  bit              m_active = 1'b0;
  bit              m_prev_start = 1'b0;
  logic [NUM_CH-1:0] m_mask = '0;
  logic [NUM_CH-1:0] m_status = '0;
  logic [XW-1:0]   m_size = XW'(DEF_SZ);
  logic [CW-1:0]   m_busy = '0;

  always @(posedge ap_clk or negedge ap_rst_n) begin
    bit sp;
    if (!ap_rst_n) begin
      m_active = 1'b0; m_prev_start = 1'b0; m_mask = '0; m_status = '0;
      m_size = XW'(DEF_SZ); m_busy = '0; m_tdone = NEVER;
    end else begin
      m_cyc++;
      sp = ap_start && !m_prev_start;
      m_prev_start = ap_start;
      if (!m_active) begin
        if (sp) begin
          m_active = 1'b1;
          m_t0     = m_cyc;
          m_mask   = ch_enable;
          m_size   = (xfer_size_in_bytes == 0) ? XW'(DEF_SZ) : xfer_size_in_bytes;
          m_status = '0;
          m_tdone  = (ch_enable == 0) ? m_cyc + 1 : NEVER;
        end
      end else if (m_cyc == m_t0 + 1) begin
        m_status = m_status;
      end else if (m_cyc <= m_tdone) begin
        m_status = m_status | (ch_done & m_mask);
        if (m_status == m_mask) m_tdone = m_cyc;
      end else begin
`ifdef TYTRA_KERNEL_CTRL_CHAIN_EN
        if (ap_continue) m_active = 1'b0;
`else
        m_active = 1'b0;
`endif
      end
      if (m_active && m_cyc == m_tdone) m_busy = CW'(m_cyc - m_t0);
    end
  end

  always @(negedge ap_clk) begin
    if (cmp_en) begin
      check("ap_idle",        ap_idle,  !m_active);
      check("ap_ready",       ap_ready, m_active && m_cyc == m_t0);
      check("ap_done",        ap_done,  m_active && m_cyc >= m_tdone);
      check("ch_start",       ch_start, (m_active && m_cyc == m_t0) ? m_mask : '0);
      check("ch_xfer_size",   ch_xfer_size, m_size);
      check("ch_done_status", ch_done_status, m_status);
      check("busy_cycles",    busy_cycles, m_busy);
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #2;
  endtask

  logic [NUM_CH-1:0] done_seq[$];

  // Leaves the bench in the LAUNCH cycle.
  task automatic launch(input logic [NUM_CH-1:0] mask, input logic [XW-1:0] size);
    ap_start = 1'b0;
    step();
    ch_enable = mask;
    xfer_size_in_bytes = size;
    ap_start = 1'b1;
    step();
  endtask

  // Drives done_seq over RUN cycles 1..N; returns in the cycle after the last entry.
  task automatic drive_seq();
    foreach (done_seq[i]) begin
      step();
      ch_done = done_seq[i];
    end
    step();
    ch_done = '0;
  endtask

  task automatic finish_run();
`ifdef TYTRA_KERNEL_CTRL_CHAIN_EN
    repeat (20) step();
    check("chain_done_held", ap_done, 1'b1);
    ap_continue = 1'b1;
    step();
    ap_continue = 1'b0;
`else
    step();
`endif
    check("idle_after_run", ap_idle, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    cmp_en = 1'b1;
    check("rst_idle", ap_idle, 1'b1);
    check("rst_size", ch_xfer_size, 32'd16384);
    check("rst_busy", busy_cycles, 0);
    ap_rst_n = 1'b1;
    step();

    // all channels, default size, staggered done (RUN cycles 3, 5, 5, 9)
    launch(4'b1111, 0);
    check("t1_ch_start", ch_start, 4'b1111);
    check("t1_ready", ap_ready, 1'b1);
    check("t1_idle", ap_idle, 1'b0);
    check("t1_size", ch_xfer_size, 32'd16384);
    done_seq = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0110,
                 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    drive_seq();
    check("t1_done", ap_done, 1'b1);
    check("t1_status", ch_done_status, 4'b1111);
    check("t1_busy", busy_cycles, 10);
    check("t1_model_busy", m_busy, 10);
    finish_run();

    // partial mask: disabled channels finish first and must be ignored
    launch(4'b0101, 4096);
    check("t2_ch_start", ch_start, 4'b0101);
    done_seq = '{4'b0000, 4'b1010, 4'b0000, 4'b0101};
    drive_seq();
    check("t2_done", ap_done, 1'b1);
    check("t2_status", ch_done_status, 4'b0101);
    check("t2_size", ch_xfer_size, 32'd4096);
    check("t2_busy", busy_cycles, 5);
    finish_run();

    // empty mask: straight to DONE after LAUNCH
    launch(4'b0000, 100);
    check("t3_ch_start", ch_start, 4'b0000);
    check("t3_ready", ap_ready, 1'b1);
    step();
    check("t3_done", ap_done, 1'b1);
    check("t3_busy", busy_cycles, 1);
    check("t3_model_busy", m_busy, 1);
    finish_run();

    // held ap_start and a second edge mid-RUN give exactly one run
    launch(4'b1111, 64);
    step(); ch_done = 4'b0001;
    step(); ch_done = 4'b0000; ap_start = 1'b0;
    step(); ap_start = 1'b1;
    step(); ch_done = 4'b1110;
    step(); ch_done = 4'b0000;
    check("t4_done", ap_done, 1'b1);
    check("t4_busy", busy_cycles, 5);
    finish_run();
    repeat (4) step();
    check("t4_no_rerun", ap_idle, 1'b1);
    launch(4'b0010, 0);
    check("t4_rerun_ready", ap_ready, 1'b1);
    done_seq = '{4'b0000, 4'b0010};
    drive_seq();
    check("t4_rerun_busy", busy_cycles, 3);
    finish_run();

    // async reset mid-RUN
    launch(4'b0011, 8);
    step(); ch_done = 4'b0001;
    step(); ch_done = 4'b0000;
    step();
    #1;
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    #1;
    check("t5_idle", ap_idle, 1'b1);
    check("t5_status", ch_done_status, 4'b0000);
    check("t5_busy", busy_cycles, 0);
    check("t5_done", ap_done, 1'b0);
    check("t5_size", ch_xfer_size, 32'd16384);
    step();
    ap_rst_n = 1'b1;
    repeat (3) step();
    check("t5_still_idle", ap_idle, 1'b1);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
